// File: rtl/tg_packet_scheduler_if.sv
// Handshake bundle between trace sources, the packet scheduler and the injector.
`ifndef TS_WIDTH
`define TS_WIDTH 10
`endif
`ifndef P_INJ
`define P_INJ 15:0
`endif

interface tg_packet_scheduler_if #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned TSW  = `TS_WIDTH
);
  logic                 enable;
  logic [TSW-1:0]       sim_time;
  logic [32*NSRC-1:0]   src_packet;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  logic                 packet_request;
  logic [31:0]          packet_out;
  logic                 packet_out_valid;
  logic [31:0]          issued_count;
  logic                 busy;

  modport master (
    output enable, sim_time, src_packet, src_valid, packet_request,
    input  src_ready, packet_out, packet_out_valid, issued_count, busy
  );

  modport slave (
    input  enable, sim_time, src_packet, src_valid, packet_request,
    output src_ready, packet_out, packet_out_valid, issued_count, busy
  );
endinterface

// File: rtl/tg_packet_scheduler.sv
// Round-robin, timestamp-gated scheduler sharing one packet injector among NSRC sources.
`ifndef TS_WIDTH
`define TS_WIDTH 10
`endif
`ifndef P_INJ
`define P_INJ 15:0
`endif

module tg_packet_scheduler #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned TSW  = `TS_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  tg_packet_scheduler_if.slave  bus
);

  localparam int unsigned PW  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned PW1 = PW + 1;

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_OFFER  = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [NSRC-1:0] r_full;
  logic [NSRC-1:0] w_full_next;
  logic [31:0]     r_pkt [NSRC];
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_next;
  logic [PW-1:0]   r_win;
  logic [PW-1:0]   w_sel;
  logic [PW1-1:0]  w_idx;
  logic            w_found;
  logic            w_grant;
  logic            w_take;
  logic [NSRC-1:0] w_elig;
  logic [31:0]     r_packet_out;
  logic [31:0]     r_count;
  logic            r_valid;
  logic            r_busy;

  // Per-entry eligibility: signed (inj - sim_time) mod 2^TSW must be <= 0
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_elig
    logic [31:0]    w_field;
    logic [TSW-1:0] w_diff;
    assign w_field    = 32'(r_pkt[gi][`P_INJ]);
    assign w_diff     = w_field[TSW-1:0] - bus.sim_time;
    assign w_elig[gi] = r_full[gi] & (w_diff[TSW-1] | (w_diff == '0));
  end

  // Round-robin search starting at the pointer, first eligible entry wins
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_idx = PW1'(r_ptr) + PW1'(k);
      if (w_idx >= PW1'(NSRC)) w_idx = w_idx - PW1'(NSRC);
      if (!w_found && w_elig[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PW-1:0];
      end
    end
  end

  // Next-state, holding-register occupancy and pointer update
  always_comb begin
    w_state_next = r_state;
    w_full_next  = r_full;
    w_ptr_next   = r_ptr;
    w_grant      = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      S_SELECT: begin
        if (w_found) begin
          w_grant      = 1'b1;
          w_state_next = S_OFFER;
        end
      end
      S_OFFER: begin
        if (bus.enable && bus.packet_request) begin
          w_take             = 1'b1;
          w_state_next       = S_HOLD;
          w_full_next[r_win] = 1'b0;
          w_ptr_next         = (r_win == PW'(NSRC - 1)) ? '0 : r_win + PW'(1);
        end
      end
      S_HOLD:  w_state_next = S_SELECT;
      default: w_state_next = S_SELECT;
    endcase
    // Loads only land in registers that were empty this cycle (no same-cycle refill)
    w_full_next = w_full_next | (bus.src_valid & ~r_full);
  end

  // Control and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_SELECT;
      r_full       <= '0;
      r_ptr        <= '0;
      r_win        <= '0;
      r_packet_out <= '0;
      r_valid      <= 1'b0;
      r_count      <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_full  <= w_full_next;
      r_ptr   <= w_ptr_next;
      r_valid <= (w_state_next == S_OFFER);
      r_busy  <= (|w_full_next) | (w_state_next != S_SELECT);
      if (w_grant) begin
        r_win        <= w_sel;
        r_packet_out <= r_pkt[w_sel];
      end
      if (w_take) r_count <= r_count + 32'd1;
    end
  end

  // Holding-register payloads; occupancy is tracked by r_full
  always_ff @(posedge clock) begin
    for (int i = 0; i < NSRC; i++) begin
      if (!reset && bus.src_valid[i] && !r_full[i]) r_pkt[i] <= bus.src_packet[32*i +: 32];
    end
  end

  assign bus.src_ready        = ~r_full;
  assign bus.packet_out       = r_packet_out;
  assign bus.packet_out_valid = r_valid;
  assign bus.issued_count     = r_count;
  assign bus.busy             = r_busy;

endmodule

// File: tb/tb_tg_packet_scheduler.sv
// Directed bench for tg_packet_scheduler: RR order, timestamp gating, wrap, back-pressure, reset.
module tb_tg_packet_scheduler;

  localparam int unsigned NSRC = 4;
  localparam int unsigned TSW  = 10;

  logic clock = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always #5 clock = ~clock;

  tg_packet_scheduler_if #(.NSRC(NSRC), .TSW(TSW)) bus ();

  tg_packet_scheduler #(.NSRC(NSRC), .TSW(TSW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mk(input logic [15:0] tag, input logic [9:0] inj);
    return {tag, 6'b000000, inj};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_pkt(input int i, input logic [31:0] p);
    bus.src_packet[32*i +: 32] = p;
  endtask

  task automatic load(input logic [3:0] mask);
    bus.src_valid = mask;
    tick();
    bus.src_valid = '0;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.enable         = 1'b1;
    bus.sim_time       = '0;
    bus.src_packet     = '0;
    bus.src_valid      = '0;
    bus.packet_request = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (bus.packet_out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (bus.packet_out_valid === 1'b1) ok = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.packet_out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.packet_out_valid); else n_pass++;
    n_total++; if (bus.packet_out !== 32'h0) $display("FAIL reset_packet: got %h exp 0", bus.packet_out); else n_pass++;
    n_total++; if (bus.issued_count !== 32'h0) $display("FAIL reset_count: got %0d exp 0", bus.issued_count); else n_pass++;
    n_total++; if (bus.src_ready !== 4'hF) $display("FAIL reset_ready: got %b exp 1111", bus.src_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] p;
    do_reset();
    p = mk(16'hA005, 10'd5);
    set_pkt(0, p);
    bus.sim_time       = 10'd5;
    bus.packet_request = 1'b1;
    load(4'b0001);
    n_total++; if (bus.src_ready !== 4'b1110) $display("FAIL single_loaded_ready: got %b exp 1110", bus.src_ready); else n_pass++;
    n_total++; if (bus.packet_out_valid !== 1'b0) $display("FAIL single_select_valid: got %b exp 0", bus.packet_out_valid); else n_pass++;
    tick();
    n_total++; if (bus.packet_out_valid !== 1'b1) $display("FAIL single_offer_valid: got %b exp 1", bus.packet_out_valid); else n_pass++;
    n_total++; if (bus.packet_out !== p) $display("FAIL single_offer_packet: got %h exp %h", bus.packet_out, p); else n_pass++;
    tick();
    n_total++; if (bus.packet_out_valid !== 1'b0) $display("FAIL single_hold_valid: got %b exp 0", bus.packet_out_valid); else n_pass++;
    n_total++; if (bus.packet_out !== p) $display("FAIL single_hold_packet: got %h exp %h", bus.packet_out, p); else n_pass++;
    n_total++; if (bus.issued_count !== 32'd1) $display("FAIL single_count: got %0d exp 1", bus.issued_count); else n_pass++;
    n_total++; if (bus.src_ready !== 4'hF) $display("FAIL single_ready_back: got %b exp 1111", bus.src_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL single_hold_busy: got %b exp 1", bus.busy); else n_pass++;
    tick();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL single_idle_busy: got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int prev;
    logic [31:0] exp_p;
    do_reset();
    bus.sim_time       = 10'd10;
    bus.packet_request = 1'b1;
    for (int i = 0; i < 4; i++) set_pkt(i, mk(16'h1000 + 16'(i), 10'd0));
    load(4'hF);
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_valid(8, ok);
      exp_p = mk(16'h1000 + 16'(g), 10'd0);
      n_total++; if (!ok) $display("FAIL rr_timeout_%0d: got no valid exp valid", g); else n_pass++;
      n_total++; if (bus.packet_out !== exp_p) $display("FAIL rr_order_%0d: got %h exp %h", g, bus.packet_out, exp_p); else n_pass++;
      if (g > 0) begin
        n_total++; if (cyc - prev != 3) $display("FAIL rr_spacing_%0d: got %0d exp 3", g, cyc - prev); else n_pass++;
      end
      prev = cyc;
      tick();
    end
    exp_p = mk(16'h1101, 10'd0);
    set_pkt(1, exp_p);
    load(4'b0010);
    wait_valid(8, ok);
    n_total++; if (!ok) $display("FAIL rr_reload_timeout: got no valid exp valid"); else n_pass++;
    n_total++; if (bus.packet_out !== exp_p) $display("FAIL rr_reload_src1: got %h exp %h", bus.packet_out, exp_p); else n_pass++;
    tick();
    n_total++; if (bus.issued_count !== 32'd5) $display("FAIL rr_count: got %0d exp 5", bus.issued_count); else n_pass++;
  endtask

  task automatic test_timestamp();
    bit ok;
    bit seen;
    do_reset();
    bus.sim_time       = 10'd10;
    bus.packet_request = 1'b1;
    set_pkt(0, mk(16'h2000, 10'd20));
    set_pkt(2, mk(16'h2002, 10'd3));
    load(4'b0101);
    wait_valid(8, ok);
    n_total++; if (!ok || bus.packet_out !== mk(16'h2002, 10'd3)) $display("FAIL ts_early_src2: got %h exp %h", bus.packet_out, mk(16'h2002, 10'd3)); else n_pass++;
    tick();
    bus.sim_time = 10'd19;
    seen = 1'b0;
    repeat (5) begin tick(); if (bus.packet_out_valid !== 1'b0) seen = 1'b1; end
    n_total++; if (seen) $display("FAIL ts_future_blocked: got valid exp no valid"); else n_pass++;
    n_total++; if (bus.src_ready !== 4'b1110) $display("FAIL ts_src0_held: got %b exp 1110", bus.src_ready); else n_pass++;
    bus.sim_time = 10'd20;
    wait_valid(8, ok);
    n_total++; if (!ok || bus.packet_out !== mk(16'h2000, 10'd20)) $display("FAIL ts_src0_due: got %h exp %h", bus.packet_out, mk(16'h2000, 10'd20)); else n_pass++;
    tick();
    n_total++; if (bus.issued_count !== 32'd2) $display("FAIL ts_count: got %0d exp 2", bus.issued_count); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    bit seen;
    do_reset();
    bus.sim_time       = 10'd1021;
    bus.packet_request = 1'b1;
    set_pkt(0, mk(16'h3000, 10'd2));
    load(4'b0001);
    seen = 1'b0;
    repeat (5) begin tick(); if (bus.packet_out_valid !== 1'b0) seen = 1'b1; end
    n_total++; if (seen) $display("FAIL wrap_1021_blocked: got valid exp no valid"); else n_pass++;
    bus.sim_time = 10'd1;
    seen = 1'b0;
    repeat (4) begin tick(); if (bus.packet_out_valid !== 1'b0) seen = 1'b1; end
    n_total++; if (seen) $display("FAIL wrap_1_blocked: got valid exp no valid"); else n_pass++;
    bus.sim_time = 10'd2;
    wait_valid(8, ok);
    n_total++; if (!ok || bus.packet_out !== mk(16'h3000, 10'd2)) $display("FAIL wrap_due: got %h exp %h", bus.packet_out, mk(16'h3000, 10'd2)); else n_pass++;
    tick();
  endtask

  task automatic test_back_pressure();
    bit ok;
    bit stable;
    logic [31:0] p;
    do_reset();
    p = mk(16'h4003, 10'd0);
    bus.sim_time       = 10'd10;
    bus.packet_request = 1'b0;
    set_pkt(3, p);
    load(4'b1000);
    wait_valid(8, ok);
    n_total++; if (!ok || bus.packet_out !== p) $display("FAIL bp_offer: got %h exp %h", bus.packet_out, p); else n_pass++;
    stable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.packet_request = (c >= 4);
      bus.enable         = (c < 4);
      tick();
      if (bus.packet_out !== p || bus.packet_out_valid !== 1'b1 || bus.issued_count !== 32'd0) stable = 1'b0;
    end
    n_total++; if (!stable) $display("FAIL bp_stall: got change exp stable offer"); else n_pass++;
    bus.packet_request = 1'b1;
    bus.enable         = 1'b1;
    tick();
    n_total++; if (bus.issued_count !== 32'd1) $display("FAIL bp_release_count: got %0d exp 1", bus.issued_count); else n_pass++;
    n_total++; if (bus.packet_out_valid !== 1'b0 || bus.packet_out !== p) $display("FAIL bp_release_hold: got %b/%h exp 0/%h", bus.packet_out_valid, bus.packet_out, p); else n_pass++;
  endtask

  task automatic test_reset_in_offer();
    bit ok;
    do_reset();
    bus.sim_time       = 10'd10;
    bus.packet_request = 1'b1;
    for (int i = 0; i < 3; i++) set_pkt(i, mk(16'h5000 + 16'(i), 10'd0));
    load(4'b0111);
    wait_valid(8, ok);
    n_total++; if (!ok || bus.packet_out !== mk(16'h5000, 10'd0)) $display("FAIL rst_first: got %h exp %h", bus.packet_out, mk(16'h5000, 10'd0)); else n_pass++;
    tick();
    bus.packet_request = 1'b0;
    wait_valid(8, ok);
    n_total++; if (!ok || bus.packet_out !== mk(16'h5001, 10'd0)) $display("FAIL rst_second_offer: got %h exp %h", bus.packet_out, mk(16'h5001, 10'd0)); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (bus.packet_out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b exp 0", bus.packet_out_valid); else n_pass++;
    n_total++; if (bus.src_ready !== 4'hF) $display("FAIL rst_mid_ready: got %b exp 1111", bus.src_ready); else n_pass++;
    n_total++; if (bus.issued_count !== 32'd0) $display("FAIL rst_mid_count: got %0d exp 0", bus.issued_count); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b exp 0", bus.busy); else n_pass++;
    reset = 1'b0;
    bus.packet_request = 1'b1;
    set_pkt(0, mk(16'h5100, 10'd0));
    set_pkt(2, mk(16'h5102, 10'd0));
    load(4'b0101);
    wait_valid(8, ok);
    n_total++; if (!ok || bus.packet_out !== mk(16'h5100, 10'd0)) $display("FAIL rst_ptr_zero: got %h exp %h", bus.packet_out, mk(16'h5100, 10'd0)); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timestamp();
    test_wrap();
    test_back_pressure();
    test_reset_in_offer();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tg_packet_scheduler.md
Name: tg_packet_scheduler

Overview:
- Shares one trace-driven packet injector between NSRC trace sources.
- Each source owns a 1-entry holding register; a round-robin scheduler picks one loaded source whose injection timestamp has arrived.
- The scheduler presents the chosen 32-bit packet to the injector's packet_in / packet_in_valid / packet_request handshake.
- packet_out is held stable through the injector's load cycle.

Parameters:
- NSRC, 4, number of trace sources (2..8).
- TSW, `TS_WIDTH, timestamp width used for eligibility compare.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  same enable that drives the injector; no handoff while low
- sim_time  in  TSW  current simulation time
- src_packet  in  32*NSRC  packet of source i in bits [32*i+31:32*i]
- src_valid  in  NSRC  source i offers a packet
- src_ready  out  NSRC  holding register i empty; load when src_valid[i]&src_ready[i]
- packet_request  in  1  injector is idle and can accept a packet
- packet_out  out  32  packet to injector packet_in
- packet_out_valid  out  1  to injector packet_in_valid
- issued_count  out  32  packets handed off since reset
- busy  out  1  any holding register full or state != SELECT

Behaviour:
- Reset, synchronous:
  - All holding registers empty, so src_ready = all ones.
  - State = SELECT, packet_out = 0, packet_out_valid = 0, issued_count = 0.
  - RR pointer = 0.
  - Reset mid-OFFER/HOLD discards the offered packet and all held packets.
- Eligibility of held packet i:
  - diff = packet[`P_INJ] (low TSW bits) - sim_time, computed modulo 2^TSW and read as signed.
  - Eligible when diff <= 0, i.e. MSB set or zero.
  - Wrap-around is therefore handled: inj=2, sim_time=2^TSW-3 gives diff=+5, not eligible.
- RR: search starts at pointer p and proceeds p, p+1, ... NSRC-1, 0, ... The first full and eligible entry wins. After a grant to i, p <= (i+1) mod NSRC.
- SELECT:
  - If any entry is full and eligible: latch the winner index and copy its packet to packet_out; go to OFFER next cycle.
  - Otherwise stay in SELECT.
  - enable is not required to select.
- OFFER:
  - packet_out_valid = 1.
  - When enable & packet_request: at that edge, clear winner's holding register, update pointer, issued_count++, go to HOLD.
  - Otherwise stay in OFFER; packet_out is stable.
  - Eligibility is not re-checked in OFFER.
- HOLD (exactly 1 cycle):
  - packet_out_valid = 0 and packet_out unchanged, because the injector samples packet_in during this cycle.
  - Then go to SELECT.
- Minimum spacing between handoffs: SELECT, OFFER, HOLD = 3 cycles.
- Holding registers:
  - src_ready[i] = ~full[i], registered state.
  - Load on src_valid & src_ready. A register freed at the OFFER edge shows src_ready = 1 from the next cycle, so there is no same-cycle refill.
  - A load in SELECT is visible to selection in the following cycle.
- issued_count wraps at 2^32.
- packet_request and the held packets are ignored in states other than the points listed above.
- Unused src_valid while the register is full has no effect.

Test Plan:
- Single source 0, packet P_INJ=5, sim_time=5:
  - SELECT in cycle 1, OFFER in cycle 2 with packet_request=1.
  - packet_out_valid high for 1 cycle, then HOLD with packet_out unchanged.
  - issued_count=1, src_ready[0] reasserts.
- Four sources all loaded with P_INJ=0, sim_time=10, packet_request always 1:
  - Grant order 0,1,2,3, each handoff 3 cycles apart.
  - Reload source 1 only; next grant is 1.
- Source 0 P_INJ=20 and source 2 P_INJ=3, sim_time=10:
  - Source 2 is granted.
  - Source 0 waits until sim_time reaches 20, then is granted.
- Wrap-around with TSW=10: P_INJ=2, sim_time=1021 -> not eligible. Advance sim_time to 2 -> granted.
- Back-pressure: packet_request=0 (or enable=0) for 7 cycles while in OFFER:
  - packet_out stable, valid held high, no count change.
  - Raise packet_request=1 and enable=1 -> handoff.
- Reset asserted in OFFER with three sources full:
  - Next cycle: valid=0, src_ready all ones, issued_count=0, pointer 0.
